alu_issue_stage: RTL

- Operand-fetch and issue stage directly upstream of the master ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and holds the 16x32 register file and the NZCV flag register.
- Presents registered Reg1/Reg2/IV/OpCode/Cond/S/Flag to the ALU.
- Tracks in-flight destinations with a scoreboard and stalls on RAW and flag hazards until the ALU's writeback returns.

---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/alu_scoreboard.sv | 106 ++++++++++
 rtl/alu_issue_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
//==============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU issue stage: opcode encodings,
//               the "always" condition code, instruction field positions,
//               controller state encoding and opcode decode helpers.
// Macros      : none (ALU_ISSUE_FORWARD_EN is consumed by the RTL modules)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

    // Opcode encodings. 1100-1111 are NOPs passed straight to the ALU.
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_RSB  = 4'b0010;
    localparam logic [3:0] OP_ADC  = 4'b0011;
    localparam logic [3:0] OP_SBC  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;   // immediate move, no Rn/Rm
    localparam logic [3:0] OP_ORR  = 4'b0111;
    localparam logic [3:0] OP_LSL  = 4'b1000;   // shifts take Rn and IV
    localparam logic [3:0] OP_LSR  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;

    localparam logic [3:0] COND_AL = 4'b1110;

    // Instruction word field positions (LSB of each field)
    localparam int unsigned F_COND_LSB = 28;
    localparam int unsigned F_OP_LSB   = 24;
    localparam int unsigned F_S_BIT    = 23;
    localparam int unsigned F_RD_LSB   = 16;
    localparam int unsigned F_RN_LSB   = 12;
    localparam int unsigned F_RM_LSB   = 8;
    localparam int unsigned F_IV_LSB   = 0;

    // Issue controller states
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_STALL = 2'b10
    } issue_state_t;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op <= OP_ASR);
    endfunction

    function automatic logic uses_rn(input logic [3:0] op);
        return (op != OP_MOVI);
    endfunction

    function automatic logic uses_rm(input logic [3:0] op);
        return (op <= OP_AND) || (op == OP_ORR) || (op == OP_CMP);
    endfunction

    // CMP always updates NZCV even without the S bit
    function automatic logic is_flag_writer(input logic s, input logic [3:0] op);
        return s || (op == OP_CMP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_scoreboard.sv
//==============================================================================
// Module      : alu_scoreboard
// Description : In-flight destination tracker for the ALU issue stage. Holds
//               one pending bit per register and a saturating count of
//               outstanding flag writers, and raises o_hazard when the
//               candidate instruction must not issue.
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_cond..i_rm      - decoded fields of the candidate instruction
//               i_issue           - candidate is transferred this cycle
//               i_wb_en/i_wb_addr - register writeback, clears pending bit
//               i_wb_flag_en      - flag writeback, retires one flag writer
//               o_hazard          - candidate must stall
// Macros      : ALU_ISSUE_FORWARD_EN - hazard check ignores bits/count being
//               retired by a writeback in the same cycle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_scoreboard
    import alu_pkg::*;
#(
    parameter int unsigned NREGS      = 16,
    parameter int unsigned FLAG_CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_op,
    input  logic       i_s,
    input  logic [3:0] i_rd,
    input  logic [3:0] i_rn,
    input  logic [3:0] i_rm,
    input  logic       i_issue,
    input  logic       i_wb_en,
    input  logic [3:0] i_wb_addr,
    input  logic       i_wb_flag_en,
    output logic       o_hazard
);

    localparam logic [FLAG_CNT_W-1:0] c_cnt_max = '1;

    logic [NREGS-1:0]      r_pending;
    logic [FLAG_CNT_W-1:0] r_flag_cnt;

    logic [NREGS-1:0]      w_set_vec;
    logic [NREGS-1:0]      w_clr_vec;
    logic [NREGS-1:0]      w_pend_eff;
    logic [FLAG_CNT_W-1:0] w_cnt_eff;
    logic                  w_flag_writer;
    logic                  w_cnt_inc;
    logic                  w_cnt_dec;

    assign w_flag_writer = is_flag_writer(i_s, i_op);
    assign w_cnt_inc     = i_issue && w_flag_writer;
    // A retire with nothing outstanding is dropped rather than wrapping
    assign w_cnt_dec     = i_wb_flag_en && (r_flag_cnt != '0);

    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (i_issue && writes_rd(i_op)) begin
            w_set_vec[i_rd] = 1'b1;
        end
        if (i_wb_en) begin
            w_clr_vec[i_wb_addr] = 1'b1;
        end
    end

`ifdef ALU_ISSUE_FORWARD_EN
    // The operands of a retiring writer are bypassed, so its bit and its
    // flag-count slot are already free as far as the candidate is concerned.
    assign w_pend_eff = r_pending & ~w_clr_vec;
    assign w_cnt_eff  = w_cnt_dec ? (r_flag_cnt - 1'b1) : r_flag_cnt;
`else
    assign w_pend_eff = r_pending;
    assign w_cnt_eff  = r_flag_cnt;
`endif

    assign o_hazard = (uses_rn(i_op)   && w_pend_eff[i_rn])
                   || (uses_rm(i_op)   && w_pend_eff[i_rm])
                   || (writes_rd(i_op) && w_pend_eff[i_rd])
                   || ((i_cond != COND_AL) && (w_cnt_eff != '0))
                   || (w_flag_writer && (w_cnt_eff == c_cnt_max));

    // Set wins over clear when issue and writeback hit the same index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_cnt <= '0;
        end else if (w_cnt_inc && !w_cnt_dec) begin
            r_flag_cnt <= r_flag_cnt + 1'b1;
        end else if (w_cnt_dec && !w_cnt_inc) begin
            r_flag_cnt <= r_flag_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
//==============================================================================
// Module      : alu_issue_stage
// Description : Operand-fetch and issue stage in front of the master ALU.
//               Holds the register file and NZCV flags, decodes the incoming
//               instruction word, stalls on RAW/WAW/flag hazards and presents
//               registered operands to the ALU over a valid/ready handshake.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               in_valid/in_ready/in_instr - instruction input handshake
//               out_valid/out_ready        - ALU operand handshake
//               Reg1, Reg2, IV, OpCode,
//               Cond, S, out_rd            - registered ALU operands
//               Flag                       - current NZCV register
//               wb_en/wb_addr/wb_data      - register writeback from ALU
//               wb_flag_en/wb_flag         - flag writeback from ALU
// Macros      : ALU_ISSUE_FORWARD_EN - same-cycle writeback bypass to operands
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned NREGS      = 16,
    parameter int unsigned FLAG_CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Reg1,
    output logic [31:0] Reg2,
    output logic [15:0] IV,
    output logic [3:0]  OpCode,
    output logic [3:0]  Cond,
    output logic        S,
    output logic [3:0]  Flag,
    output logic [3:0]  out_rd,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        wb_flag_en,
    input  logic [3:0]  wb_flag
);

    issue_state_t r_state;
    issue_state_t w_state_next;

    logic [31:0] r_rf [NREGS];
    logic [3:0]  r_flag;

    logic [3:0]  w_cond;
    logic [3:0]  w_op;
    logic        w_s;
    logic [3:0]  w_rd;
    logic [3:0]  w_rn;
    logic [3:0]  w_rm;
    logic [15:0] w_iv;
    logic [31:0] w_rn_data;
    logic [31:0] w_rm_data;
    logic        w_hazard;
    logic        w_fire;
    logic        w_unused_fields;

    assign w_cond = in_instr[F_COND_LSB +: 4];
    assign w_op   = in_instr[F_OP_LSB   +: 4];
    assign w_s    = in_instr[F_S_BIT];
    assign w_rd   = in_instr[F_RD_LSB   +: 4];
    assign w_rn   = in_instr[F_RN_LSB   +: 4];
    assign w_rm   = in_instr[F_RM_LSB   +: 4];
    assign w_iv   = in_instr[F_IV_LSB   +: 16];
    assign w_unused_fields = ^in_instr[22:20];

    alu_scoreboard #(
        .NREGS      (NREGS),
        .FLAG_CNT_W (FLAG_CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cond       (w_cond),
        .i_op         (w_op),
        .i_s          (w_s),
        .i_rd         (w_rd),
        .i_rn         (w_rn),
        .i_rm         (w_rm),
        .i_issue      (w_fire),
        .i_wb_en      (wb_en),
        .i_wb_addr    (wb_addr),
        .i_wb_flag_en (wb_flag_en),
        .o_hazard     (w_hazard)
    );

    // Ready is derived from the state register rather than out_valid so the
    // next-state logic below never loops back through its own output.
    assign in_ready = rst_n && !w_hazard && ((r_state != ST_FULL) || out_ready);
    assign w_fire   = in_valid && in_ready;

`ifdef ALU_ISSUE_FORWARD_EN
    assign w_rn_data = (wb_en && (wb_addr == w_rn)) ? wb_data : r_rf[w_rn];
    assign w_rm_data = (wb_en && (wb_addr == w_rm)) ? wb_data : r_rf[w_rm];
`else
    assign w_rn_data = r_rf[w_rn];
    assign w_rm_data = r_rf[w_rm];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        case (r_state)
            ST_FULL: begin
                out_valid = 1'b1;
                if (w_fire) begin
                    w_state_next = ST_FULL;
                end else if (out_ready) begin
                    w_state_next = (in_valid && w_hazard) ? ST_STALL : ST_EMPTY;
                end
            end
            default: begin
                if (w_fire) begin
                    w_state_next = ST_FULL;
                end else if (in_valid && w_hazard) begin
                    w_state_next = ST_STALL;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
        endcase
    end

    // Output register: loads only on a transfer, so it holds while the ALU
    // back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Reg1   <= '0;
            Reg2   <= '0;
            IV     <= '0;
            OpCode <= '0;
            Cond   <= '0;
            S      <= 1'b0;
            out_rd <= '0;
        end else if (w_fire) begin
            Reg1   <= w_rn_data;
            Reg2   <= w_rm_data;
            IV     <= w_iv;
            OpCode <= w_op;
            Cond   <= w_cond;
            S      <= w_s;
            out_rd <= w_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
        end else if (wb_flag_en) begin
            r_flag <= wb_flag;
        end
    end

    assign Flag = r_flag;

endmodule

`default_nettype wire
